uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter path of uart_top between NUM_REQ byte requesters using round-robin arbitration. It accepts one byte per valid/ready handshake and drives data_in/tx_start into uart_top. It waits for the frame to complete, signalled by a rising edge on tx_done, before granting again. A watchdog recovers if tx_done never arrives.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, arbiter FSM state type and default watchdog limit.
package uart_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  localparam int unsigned CLK_FREQ        = 100_000_000;
  localparam int unsigned BAUD            = 9600;
  localparam int unsigned BAUD_CNT_CYCLES = CLK_FREQ / (BAUD * 16);

  // One 9600-baud frame at 100 MHz is ~104k cycles; leave margin.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 120_000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bus plus UART TX-side signals of the TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BYTE_WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*BYTE_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [BYTE_WIDTH-1:0]         tx_data;
  logic                          tx_start;
  logic                          tx_done;
  logic                          busy;
  logic [IDX_W-1:0]              grant_id;
  logic                          timeout_err;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data, tx_start, busy, grant_id, timeout_err
  );

  // Requesters / UART side.
  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data, tx_start, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid after ptr, modulo NUM_REQ.
module uart_rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_valid_o
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Scan farthest offset first so the nearest valid after ptr wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      cand = IDX_W'((32'(ptr_i) + 32'(i)) % NUM_REQ);
      if (valid_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  assign any_valid_o = |valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters,
// with a frame-completion watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BYTE_WIDTH     = uart_pkg::BYTE_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = uart_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              arst_n,
  uart_tx_arbiter_if.slave bus
);
  import uart_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_PRE  = WD_W'(TIMEOUT_CYCLES - 2);

  uart_arb_state_t       state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  done_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               handshake_c;
  logic               done_rise_c;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid_i     (bus.req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (pick_grant),
    .idx_o       (pick_idx),
    .any_valid_o (pick_any)
  );

  assign req_ready_c = (state_q == IDLE && pick_any) ? pick_grant : '0;
  assign handshake_c = |(bus.req_valid & req_ready_c);
  assign done_rise_c = bus.tx_done & ~done_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      wd_q       <= wd_d;
      done_q     <= bus.tx_done;
    end
  end

  // Timeout decided one count early so the registered pulse lands exactly
  // TIMEOUT_CYCLES after tx_start; a simultaneous tx_done edge takes priority.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake_c) begin
          ptr_d   = pick_idx;
          grant_d = pick_idx;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_grant[i]) tx_data_d = bus.req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
          state_d = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wd_q != WD_TERM) wd_d = wd_q + WD_W'(1);
        if (done_rise_c) begin
          state_d = IDLE;
        end else if (wd_q == WD_PRE) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 200-cycle watchdog).
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned BW      = 8;
  localparam int unsigned TO      = 200;

  logic clk;
  logic arst_n;
  int   errors = 0;
  int   checks = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .BYTE_WIDTH(BW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .BYTE_WIDTH     (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction for an already-presented request: accept, start, wait, complete.
  task automatic serve(input int id, input logic [7:0] data, input string tag);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(4'b0001 << id));
    cyc();
    chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    chk({tag, "_gid"},   32'(bus.grant_id), 32'(id));
    chk({tag, "_data"},  32'(bus.tx_data),  32'(data));
    chk({tag, "_busy"},  32'(bus.busy),     32'd1);
    chk({tag, "_rdy0"},  32'(bus.req_ready), 32'd0);
    cyc();
    chk({tag, "_start0"}, 32'(bus.tx_start), 32'd0);
    repeat (3) cyc();
    chk({tag, "_busyw"}, 32'(bus.busy), 32'd1);
    bus.tx_done = 1'b1;
    cyc();
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    bus.tx_done = 1'b0;
  endtask

  initial begin
    arst_n        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    repeat (2) cyc();

    chk("rst_start",   32'(bus.tx_start),    32'd0);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_gid",     32'(bus.grant_id),    32'd0);
    chk("rst_data",    32'(bus.tx_data),     32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rst_ready",   32'(bus.req_ready),   32'd0);
    arst_n = 1'b1;
    cyc();

    // Single request
    bus.req_data  = 32'h0000_00A5;
    bus.req_valid = 4'b0001;
    serve(0, 8'hA5, "single");
    bus.req_valid = 4'b0000;
    cyc();
    chk("single_hold", 32'(bus.tx_data), 32'hA5);

    // Re-reset so the pointer starts at NUM_REQ-1 again
    arst_n = 1'b0;
    cyc();
    arst_n = 1'b1;
    cyc();

    // All four held valid: strict rotation
    bus.req_data  = 32'h4332_2110;
    bus.req_valid = 4'b1111;
    serve(0, 8'h10, "rr0");
    serve(1, 8'h21, "rr1");
    serve(2, 8'h32, "rr2");
    serve(3, 8'h43, "rr3");
    serve(0, 8'h10, "rr4");
    serve(1, 8'h21, "rr5");

    // Fairness: after 2, requester 3 precedes 0
    bus.req_valid = 4'b0100;
    serve(2, 8'h32, "fair2");
    bus.req_valid = 4'b1001;
    serve(3, 8'h43, "fair3");
    serve(0, 8'h10, "fair0");
    bus.req_valid = 4'b0000;
    cyc();

    // Watchdog with tx_done held low
    bus.req_valid = 4'b0010;
    #1;
    chk("wd_ready", 32'(bus.req_ready), 32'b0010);
    cyc();
    chk("wd_start", 32'(bus.tx_start), 32'd1);
    chk("wd_gid",   32'(bus.grant_id), 32'd1);
    bus.req_valid = 4'b0000;
    repeat (TO - 1) cyc();
    chk("wd_early_err",  32'(bus.timeout_err), 32'd0);
    chk("wd_early_busy", 32'(bus.busy),        32'd1);
    cyc();
    chk("wd_err",      32'(bus.timeout_err), 32'd1);
    chk("wd_err_idle", 32'(bus.busy),        32'd0);

    // Next request accepted after timeout; tx_done held high from the start
    bus.req_valid = 4'b0100;
    bus.tx_done   = 1'b1;
    #1;
    chk("post_wd_ready", 32'(bus.req_ready), 32'b0100);
    cyc();
    chk("wd_err_pulse", 32'(bus.timeout_err), 32'd0);
    chk("lvl_start",    32'(bus.tx_start),    32'd1);
    chk("lvl_gid",      32'(bus.grant_id),    32'd2);
    chk("lvl_data",     32'(bus.tx_data),     32'h32);
    bus.req_valid = 4'b0000;
    repeat (4) cyc();
    chk("lvl_no_early", 32'(bus.busy), 32'd1);
    bus.tx_done = 1'b0;
    cyc();
    chk("lvl_fall", 32'(bus.busy), 32'd1);
    bus.tx_done = 1'b1;
    cyc();
    chk("lvl_done", 32'(bus.busy), 32'd0);
    bus.tx_done = 1'b0;
    cyc();

    // Reset in the middle of WAIT_DONE
    bus.req_valid = 4'b1000;
    #1;
    chk("mid_ready", 32'(bus.req_ready), 32'b1000);
    cyc();
    bus.req_valid = 4'b0000;
    repeat (2) cyc();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_start", 32'(bus.tx_start),    32'd0);
    chk("mid_rst_busy",  32'(bus.busy),        32'd0);
    chk("mid_rst_gid",   32'(bus.grant_id),    32'd0);
    chk("mid_rst_data",  32'(bus.tx_data),     32'd0);
    chk("mid_rst_err",   32'(bus.timeout_err), 32'd0);
    cyc();
    bus.req_valid = 4'b0110;
    arst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'b0010);
    cyc();
    chk("post_rst_start", 32'(bus.tx_start), 32'd1);
    chk("post_rst_gid",   32'(bus.grant_id), 32'd1);
    chk("post_rst_data",  32'(bus.tx_data),  32'h21);
    bus.req_valid = 4'b0000;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
